receiver_native: RTL

- UART receive path; the counterpart of the native-interface transmitter.
- Deserialises an 8N1-style asynchronous serial line into parallel words.
- Pushes each good word into a downstream FIFO through a native write interface (`dout`/`we`/`full`).
- Sits between the external RX pin and the RX FIFO of the UART core.

---
 rtl/receiver_native.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/receiver_native.sv
// receiver_native
//   UART receive path. Deserialises an 8N1-style asynchronous line (idle
//   high, LSB first) and pushes each good word into a downstream FIFO
//   through a native write interface.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          synchronous active-low reset
//     din          asynchronous serial input
//     full         downstream FIFO full (looked at only in DONE)
//     dout         last good word, updated together with we
//     we           one-cycle write strobe per good word
//     framing_err  one-cycle pulse when the stop bit reads 0
//     overrun_err  one-cycle pulse when a good word is dropped on full
//     parity_err   one-cycle pulse on even-parity mismatch
//
//   Build option: define SIMPLE_UART_PARITY_EN to expect an even-parity
//   bit between the last data bit and the stop bit. Without it there is
//   no parity stage and parity_err is tied low.
module receiver_native #(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  full,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  we,
    output logic                  framing_err,
    output logic                  overrun_err,
    output logic                  parity_err
);

    localparam int unsigned CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned HALF   = CYCLES / 2;
    localparam int unsigned CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int unsigned IDX_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q, sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic [WORD_WIDTH-1:0]   dout_q, dout_d;
    logic                    we_q, we_d;
    logic                    ferr_q, ferr_d;
    logic                    oerr_q, oerr_d;
`ifdef SIMPLE_UART_PARITY_EN
    logic                    par_q, par_d;
    logic                    perr_q, perr_d;
`endif
    logic                    rx_s;
    logic                    bit_end;

    assign sync_d  = {sync_q[0], din};
    assign rx_s    = sync_q[1];
    assign bit_end = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
`ifdef SIMPLE_UART_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
`ifdef SIMPLE_UART_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef SIMPLE_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // Re-check the line half a bit in; a high level means the
                // falling edge was a glitch and is silently dropped.
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[WORD_WIDTH-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef SIMPLE_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SIMPLE_UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_DONE : S_BREAK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Hold here while the line stays low so a break condition
            // cannot be mistaken for a new start bit.
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: status pulses are registered so dout and we change together
    always_comb begin
        we_d   = 1'b0;
        ferr_d = 1'b0;
        oerr_d = 1'b0;
        dout_d = dout_q;
`ifdef SIMPLE_UART_PARITY_EN
        perr_d = 1'b0;
`endif
        if (state_q == S_STOP && bit_end && !rx_s) begin
            ferr_d = 1'b1;
        end
        if (state_q == S_DONE) begin
`ifdef SIMPLE_UART_PARITY_EN
            if (^{shift_q, par_q}) begin
                perr_d = 1'b1;
            end else
`endif
            if (full) begin
                oerr_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                dout_d = shift_q;
            end
        end
    end

    assign dout        = dout_q;
    assign we          = we_q;
    assign framing_err = ferr_q;
    assign overrun_err = oerr_q;
`ifdef SIMPLE_UART_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
